// File: rtl/riscv.sv
// Shared RISC-V control-transfer record types used by the record buffer.
package riscv;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-2:0] pc;
    logic            v;
  } ctrsource_rv_t;

  typedef struct packed {
    logic [XLEN-2:0] pc;
    logic            misp;
  } ctrtarget_rv_t;

  typedef logic [3:0] ctr_type_t;

  typedef enum logic [1:0] {
    PRIV_LVL_U  = 2'b00,
    PRIV_LVL_S  = 2'b01,
    PRIV_LVL_HS = 2'b10,
    PRIV_LVL_M  = 2'b11
  } priv_lvl_t;

endpackage

// File: rtl/ctr_record_buffer.sv
// Control-transfer record buffer: filters emitted records, stores them in a
// circular buffer tagged with idle-cycle counts, and serves logical-index reads
// (index 0 = most recent record).
module ctr_record_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CC_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  riscv::ctrsource_rv_t  emitter_source_i,
  input  riscv::ctrtarget_rv_t  emitter_target_i,
  input  riscv::ctr_type_t      emitter_data_i,
  input  logic [31:0]           emitter_instr_i,
  input  riscv::priv_lvl_t      priv_lvl_i,
  input  logic [2:0]            priv_en_i,
  input  logic [15:0]           type_mask_i,
  input  logic                  freeze_i,
  input  logic                  clear_i,
  input  logic [2:0]            depth_sel_i,
  input  logic                  rd_req_i,
  input  logic [7:0]            rd_idx_i,
  output logic                  rd_valid_o,
  output riscv::ctrsource_rv_t  rd_source_o,
  output riscv::ctrtarget_rv_t  rd_target_o,
  output riscv::ctr_type_t      rd_type_o,
  output logic                  rd_ccv_o,
  output logic [CC_W-1:0]       rd_cc_o,
  output logic [7:0]            wrptr_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned EDW = 12;

  typedef struct packed {
    riscv::ctrsource_rv_t  source;
    riscv::ctrtarget_rv_t  target;
    riscv::ctr_type_t      ctype;
    logic                  ccv;
    logic [CC_W-1:0]       cc;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     wrptr_q, wrptr_d;
  logic [CC_W-1:0]   cnt_q, cnt_d;
  logic              started_q, started_d;
  logic              rd_valid_q;
  entry_t            rd_entry_q;

  logic [EDW-1:0]    ed_c;
  logic [PW-1:0]     mask_c;
  logic              priv_ok_c;
  logic              accept_c;
  logic [PW-1:0]     rd_p_c;
  logic              rd_hit_c;
  entry_t            wr_entry_c;

  // The instruction word is carried on the interface for a future trace mode.
  logic unused_instr_c;
  assign unused_instr_c = ^emitter_instr_i;

  // Effective depth and wrap mask from the depth selector.
  always_comb begin
    ed_c = EDW'(16) << depth_sel_i;
    if (ed_c > EDW'(DEPTH)) ed_c = EDW'(DEPTH);
    mask_c = PW'(ed_c - EDW'(1));
  end

  // Record filter: privilege enables (reserved level never passes) and type mask.
  always_comb begin
    priv_ok_c = 1'b0;
    case (priv_lvl_i)
      riscv::PRIV_LVL_U: priv_ok_c = priv_en_i[0];
      riscv::PRIV_LVL_S: priv_ok_c = priv_en_i[1];
      riscv::PRIV_LVL_M: priv_ok_c = priv_en_i[2];
      default:           priv_ok_c = 1'b0;
    endcase
    accept_c = emitter_source_i.v & ~freeze_i & ~clear_i & priv_ok_c
             & ~type_mask_i[emitter_data_i];
  end

  // Logical-to-physical read index, based on the pointer before any same-cycle write.
  always_comb begin
    rd_p_c   = (wrptr_q - PW'(1) - PW'(rd_idx_i)) & mask_c;
    rd_hit_c = (EDW'(rd_idx_i) < ed_c) && valid_q[rd_p_c];
  end

  // Next-state for pointer, valid bits and the idle-cycle counter.
  always_comb begin
    valid_d    = valid_q;
    wrptr_d    = wrptr_q & mask_c;
    cnt_d      = cnt_q;
    started_d  = started_q;
    wr_entry_c = '{source: emitter_source_i, target: emitter_target_i,
                   ctype: emitter_data_i, ccv: started_q, cc: cnt_q};
    if (clear_i) begin
      valid_d   = '0;
      wrptr_d   = '0;
      cnt_d     = '0;
      started_d = 1'b0;
    end else if (accept_c) begin
      valid_d[wrptr_q] = 1'b1;
      wrptr_d          = (wrptr_q + PW'(1)) & mask_c;
      cnt_d            = '0;
      started_d        = 1'b1;
    end else if (started_q && !freeze_i && (cnt_q != {CC_W{1'b1}})) begin
      cnt_d = cnt_q + CC_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      wrptr_q   <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wrptr_q   <= wrptr_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
    end
  end

  // Record storage; contents are qualified by the valid bits, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept_c) mem_q[wrptr_q] <= wr_entry_c;
  end

  // Registered read port; data holds when no request is made.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_entry_q <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      if (rd_req_i) rd_entry_q <= rd_hit_c ? mem_q[rd_p_c] : '0;
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_source_o = rd_entry_q.source;
  assign rd_target_o = rd_entry_q.target;
  assign rd_type_o   = rd_entry_q.ctype;
  assign rd_ccv_o    = rd_entry_q.ccv;
  assign rd_cc_o     = rd_entry_q.cc;
  assign wrptr_o     = 8'(wrptr_q);

endmodule
